occ_line_fetch_responder: RTL

// Responder end of the stage-3 occurrence lookup request interface. Stage 3 presents a
// k/l line-address pair with valid and holds it while stalled. This block accepts each pair
// and issues one or two reads to the memory read port. It pairs the in-order read data into
// one {line_k, line_l} response and returns it, tagged, to the stage that computes occurrences.

---
 rtl/occ_line_fetch_responder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/occ_line_fetch_responder.sv
// Occurrence lookup line fetch responder.
// Accepts k/l line-address pairs, issues one read (same line) or two reads (split pair),
// then pairs the in-order read data into one tagged {line_k, line_l} response.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | ready for a new pair (if pending FIFO not full)
// S_ISSUE_K | presenting the read command for addr_k
// S_ISSUE_L | presenting the read command for addr_l (split pairs only)
module occ_line_fetch_responder #(
   parameter int ADDR_W = 42,
   parameter int DATA_W = 512,
   parameter int TAG_W  = 15,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr_k,
   input  logic [ADDR_W-1:0] req_addr_l,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              mem_rd_valid,
   input  logic              mem_rd_ready,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              mem_resp_valid,
   output logic              mem_resp_ready,
   input  logic [DATA_W-1:0] mem_resp_data,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_line_k,
   output logic [DATA_W-1:0] resp_line_l,
   output logic [TAG_W-1:0]  resp_tag,
   output logic              err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE_K, S_ISSUE_L} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr_k;
   logic [ADDR_W-1:0] r_addr_l;
   logic              r_same;

   logic [TAG_W-1:0]  r_fifo_tag  [DEPTH];
   logic              r_fifo_same [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_cnt;

   logic              r_half;
   logic              r_resp_valid;
   logic [DATA_W-1:0] r_line_k;
   logic [DATA_W-1:0] r_line_l;
   logic [TAG_W-1:0]  r_tag;
   logic              r_err;

   logic              w_accept;
   logic              w_empty;
   logic              w_beat;
   logic              w_head_same;
   logic [TAG_W-1:0]  w_head_tag;
   logic              w_pop;

   assign req_ready      = (r_state == S_IDLE) && (r_cnt < CNT_W'(DEPTH));
   assign w_accept       = req_valid & req_ready;
   assign w_empty        = (r_cnt == '0);
   assign mem_resp_ready = ~r_resp_valid | resp_ready;
   assign w_beat         = mem_resp_valid & mem_resp_ready;
   assign w_head_same    = r_fifo_same[r_rd_ptr];
   assign w_head_tag     = r_fifo_tag[r_rd_ptr];
   // A request retires on its last beat: the only beat if same-line, the second otherwise.
   assign w_pop          = w_beat & ~w_empty & (w_head_same | r_half);

   assign resp_valid  = r_resp_valid;
   assign resp_line_k = r_line_k;
   assign resp_line_l = r_line_l;
   assign resp_tag    = r_tag;
   assign err         = r_err;

   // Issue FSM state register and latched address pair.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_addr_k <= '0;
         r_addr_l <= '0;
         r_same   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_addr_k <= req_addr_k;
            r_addr_l <= req_addr_l;
            r_same   <= (req_addr_k == req_addr_l);
         end
      end
   end

   // Issue FSM next state and read command outputs.
   always_comb begin
      w_state_nxt  = r_state;
      mem_rd_valid = 1'b0;
      mem_rd_addr  = r_addr_k;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_ISSUE_K;
         end
         S_ISSUE_K: begin
            mem_rd_valid = 1'b1;
            if (mem_rd_ready) w_state_nxt = r_same ? S_IDLE : S_ISSUE_L;
         end
         S_ISSUE_L: begin
            mem_rd_valid = 1'b1;
            mem_rd_addr  = r_addr_l;
            if (mem_rd_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pending FIFO storage; contents are qualified by the count, so no reset needed.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_fifo_tag[r_wr_ptr]  <= req_tag;
         r_fifo_same[r_wr_ptr] <= (req_addr_k == req_addr_l);
      end
   end

   // Pending FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_accept, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Beat pairing, response register and sticky stray-beat error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_half       <= 1'b0;
         r_resp_valid <= 1'b0;
         r_line_k     <= '0;
         r_line_l     <= '0;
         r_tag        <= '0;
         r_err        <= 1'b0;
      end else begin
         if (w_beat && w_empty) r_err <= 1'b1;
         // A beat is only taken when the held response is absent or leaving this cycle,
         // so overwriting line_k with the first half never disturbs a stalled response.
         if (w_beat && !w_empty) begin
            if (w_head_same) begin
               r_line_k <= mem_resp_data;
               r_line_l <= mem_resp_data;
               r_tag    <= w_head_tag;
            end else if (!r_half) begin
               r_line_k <= mem_resp_data;
               r_half   <= 1'b1;
            end else begin
               r_line_l <= mem_resp_data;
               r_tag    <= w_head_tag;
               r_half   <= 1'b0;
            end
         end
         if (w_pop)           r_resp_valid <= 1'b1;
         else if (resp_ready) r_resp_valid <= 1'b0;
      end
   end

endmodule
